// File: rtl/dac_spi_if.sv
// FIFO-pop and SPI pins shared by dac_spi_tx and its neighbours.
// The master is the transmitter; the slave side is the FIFO plus the DAC.
interface dac_spi_if #(
  parameter int DATA_W = 32
);
  logic              empty_dac;
  logic              rd_dac;
  logic [DATA_W-1:0] dac_fifo_out;
  logic              sclk;
  logic              cs_n;
  logic              mosi;

  modport master (
    input  empty_dac, dac_fifo_out,
    output rd_dac, sclk, cs_n, mosi
  );

  modport slave (
    output empty_dac, dac_fifo_out,
    input  rd_dac, sclk, cs_n, mosi
  );
endinterface

// File: rtl/dac_spi_tx.sv
// Pops words from the DAC FIFO and shifts them MSB-first over SPI mode 0.
// Counts completed frames and flags a sticky underrun once streaming has started.
module dac_spi_tx #(
  parameter int DATA_W    = 32,
  parameter int CLK_DIV   = 2,
  parameter int FRAME_GAP = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  dac_spi_if.master    dif,
  output logic         busy,
  output logic [15:0]  frame_cnt,
  output logic         underrun
);
  localparam int DIV_W = (CLK_DIV   > 1) ? $clog2(CLK_DIV)   : 1;
  localparam int BIT_W = (DATA_W    > 1) ? $clog2(DATA_W)    : 1;
  localparam int GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FRAME_GAP - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;

  state_e              state_q, state_d;
  // Holds only the bits still to be sent; the current bit lives in mosi_q.
  logic [DATA_W-2:0]   shift_q, shift_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                sclk_q, sclk_d;
  logic                cs_n_q, cs_n_d;
  logic                mosi_q, mosi_d;
  logic                busy_q, busy_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                underrun_q, underrun_d;
  logic                started_q, started_d;
  logic                rd;

  assign rd = (state_q == IDLE) && enable && !dif.empty_dac && !rst;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    div_d       = div_q;
    bit_d       = bit_q;
    gap_d       = gap_q;
    sclk_d      = sclk_q;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;
    frame_cnt_d = frame_cnt_q;
    underrun_d  = underrun_q;
    started_d   = started_q;
    case (state_q)
      IDLE: begin
        if (rd) begin
          state_d = SHIFT;
          shift_d = dif.dac_fifo_out[DATA_W-2:0];
          mosi_d  = dif.dac_fifo_out[DATA_W-1];
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
        end else if (enable && dif.empty_dac && started_q) begin
          underrun_d = 1'b1;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling sclk: either advance to the next bit or close the frame.
            sclk_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              state_d     = GAP;
              cs_n_d      = 1'b1;
              mosi_d      = 1'b0;
              gap_d       = '0;
              frame_cnt_d = frame_cnt_q + 16'd1;
              started_d   = 1'b1;
            end else begin
              bit_d   = bit_q + 1'b1;
              mosi_d  = shift_q[DATA_W-2];
              shift_d = shift_q << 1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      gap_q       <= '0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      underrun_q  <= 1'b0;
      started_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      gap_q       <= gap_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
      mosi_q      <= mosi_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
      underrun_q  <= underrun_d;
      started_q   <= started_d;
    end
  end

  assign dif.rd_dac = rd;
  assign dif.sclk   = sclk_q;
  assign dif.cs_n   = cs_n_q;
  assign dif.mosi   = mosi_q;
  assign busy       = busy_q;
  assign frame_cnt  = frame_cnt_q;
  assign underrun   = underrun_q;
endmodule

// File: tb/tb_dac_spi_tx.sv
// Scoreboard bench: pushed words are queued as expected frames, an SPI monitor
// rebuilds each frame from mosi at sclk rising edges and compares.
module tb_dac_spi_tx;
  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, en_b;
  logic        busy_a, busy_b, ur_a, ur_b;
  logic [15:0] fc_a, fc_b;

  always #5 clk = ~clk;

  dac_spi_if #(.DATA_W(32)) ifa ();
  dac_spi_if #(.DATA_W(8))  ifb ();

  dac_spi_tx #(.DATA_W(32), .CLK_DIV(2), .FRAME_GAP(2)) dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .dif(ifa),
    .busy(busy_a), .frame_cnt(fc_a), .underrun(ur_a));

  dac_spi_tx #(.DATA_W(8), .CLK_DIV(1), .FRAME_GAP(2)) dut_b (
    .clk(clk), .rst(rst), .enable(en_b), .dif(ifb),
    .busy(busy_b), .frame_cnt(fc_b), .underrun(ur_b));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO model (first-word-fall-through) and scoreboard
  logic [31:0] fifo[$];
  logic [31:0] exp_q[$];

  task automatic fifo_upd();
    ifa.empty_dac    = (fifo.size() == 0);
    ifa.dac_fifo_out = (fifo.size() != 0) ? fifo[0] : 32'h0;
  endtask

  task automatic push(input logic [31:0] w);
    fifo.push_back(w);
    exp_q.push_back(w);
    fifo_upd();
  endtask

  logic pop_pend;
  always begin
    @(negedge clk);
    pop_pend = ifa.rd_dac;
    @(posedge clk);
    #1;
    if (pop_pend) begin
      chk("pop_nonempty", 32'(fifo.size() != 0), 32'd1);
      if (fifo.size() != 0) void'(fifo.pop_front());
      fifo_upd();
    end
  end

  // Monitor for dut_a
  int          cyc = 0, rd_cnt = 0, low_len = 0, hi_len = 0, rise_cnt = 0;
  int          rd_times[$];
  int          hi_lens[$];
  logic        cs_prev = 1'b1, sclk_prev = 1'b0, have_prev = 1'b0, abort_pend = 1'b0;
  logic [31:0] word = '0;

  always @(negedge clk) begin
    cyc++;
    if (ifa.rd_dac === 1'b1) begin
      rd_cnt++;
      rd_times.push_back(cyc);
    end
    if (ifa.cs_n === 1'b0) begin
      if (cs_prev) begin
        if (have_prev) hi_lens.push_back(hi_len);
        low_len = 0; rise_cnt = 0; word = '0;
      end
      low_len++;
      if (ifa.sclk && !sclk_prev) begin
        word = {word[30:0], ifa.mosi};
        rise_cnt++;
      end
    end else begin
      if (!cs_prev) begin
        if (abort_pend) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          abort_pend = 1'b0;
        end else begin
          chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            chk("frame_word", word, exp_q.pop_front());
            chk("frame_bits", 32'(rise_cnt), 32'd32);
            chk("cs_low_len", 32'(low_len), 32'd128);
          end
        end
        hi_len    = 1;
        have_prev = 1'b1;
      end else begin
        hi_len++;
      end
    end
    cs_prev   = ifa.cs_n;
    sclk_prev = ifa.sclk;
  end

  // Monitor for dut_b (8-bit, CLK_DIV=1)
  int         b_low = 0, b_rise = 0;
  logic [7:0] b_word = '0;
  logic       b_cs_prev = 1'b1, b_sclk_prev = 1'b0;

  always @(negedge clk) begin
    if (ifb.cs_n === 1'b0) begin
      if (b_cs_prev) begin b_low = 0; b_rise = 0; b_word = '0; end
      b_low++;
      if (ifb.sclk && !b_sclk_prev) begin
        b_word = {b_word[6:0], ifb.mosi};
        b_rise++;
      end
    end
    b_cs_prev   = ifb.cs_n;
    b_sclk_prev = ifb.sclk;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_frames(input logic [15:0] n);
    for (int i = 0; i < 3000 && fc_a != n; i++) @(negedge clk);
    chk("frame_cnt_reach", 32'(fc_a), 32'(n));
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    rd_cnt = 0;
    rd_times.delete();
    hi_lens.delete();
    have_prev = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en_a = 1'b1; en_b = 1'b0;
    fifo_upd();
    ifb.empty_dac = 1'b1; ifb.dac_fifo_out = 8'h00;
    tick(3);
    // Reset values, with a word already waiting: rst must block the pop
    push(32'hA5C3_0F81);
    #1;
    chk("rst_sclk",  32'(ifa.sclk),   32'd0);
    chk("rst_cs_n",  32'(ifa.cs_n),   32'd1);
    chk("rst_mosi",  32'(ifa.mosi),   32'd0);
    chk("rst_busy",  32'(busy_a),     32'd0);
    chk("rst_fc",    32'(fc_a),       32'd0);
    chk("rst_ur",    32'(ur_a),       32'd0);
    chk("rst_rd",    32'(ifa.rd_dac), 32'd0);

    // Single frame
    rd_cnt = 0;
    rst = 1'b0;
    wait_frames(16'd1);
    tick();
    chk("single_rd_pulses", 32'(rd_cnt), 32'd1);
    en_a = 1'b0;

    // Back-to-back frames
    reset_dut();
    push(32'h0123_4567); push(32'hFFFF_0000); push(32'h8000_0001);
    en_a = 1'b1;
    for (int i = 0; i < 1000 && rd_cnt < 3; i++) tick();
    chk("b2b_pops", 32'(rd_cnt), 32'd3);
    en_a = 1'b0;
    wait_frames(16'd3);
    tick();
    if (rd_times.size() >= 3) begin
      chk("b2b_period01", 32'(rd_times[1] - rd_times[0]), 32'd131);
      chk("b2b_period12", 32'(rd_times[2] - rd_times[1]), 32'd131);
    end
    chk("b2b_gap_count", 32'(hi_lens.size()), 32'd2);
    if (hi_lens.size() >= 2) begin
      chk("b2b_gap0", 32'(hi_lens[0]), 32'd3);
      chk("b2b_gap1", 32'(hi_lens[1]), 32'd3);
    end
    chk("b2b_ur", 32'(ur_a), 32'd0);

    // Underrun: none before any frame, sticky after the FIFO drains
    reset_dut();
    en_a = 1'b1;
    tick(20);
    chk("ur_before_start", 32'(ur_a), 32'd0);
    push(32'h11AA_22BB); push(32'h5566_7788);
    wait_frames(16'd2);
    @(negedge clk);
    chk("ur_in_gap", 32'(ur_a), 32'd0);
    repeat (2) @(negedge clk);
    chk("ur_after_drain", 32'(ur_a), 32'd1);
    tick();
    push(32'h9ABC_DEF0);
    wait_frames(16'd3);
    chk("ur_sticky", 32'(ur_a), 32'd1);
    en_a = 1'b0;
    tick();

    // enable dropped mid-SHIFT: frame completes, no pop until re-enabled
    reset_dut();
    push(32'hCAFE_F00D); push(32'h0F0F_A5A5);
    en_a = 1'b1;
    for (int i = 0; i < 100 && ifa.cs_n !== 1'b0; i++) tick();
    tick(40);
    en_a = 1'b0;
    wait_frames(16'd1);
    tick(300);
    chk("en_no_pop", 32'(rd_cnt), 32'd1);
    chk("en_idle_busy", 32'(busy_a), 32'd0);
    en_a = 1'b1;
    #1;
    chk("en_rd_on_reenable", 32'(ifa.rd_dac), 32'd1);
    wait_frames(16'd2);
    en_a = 1'b0;
    tick();

    // Reset at the 10th sclk rising edge aborts the frame
    reset_dut();
    en_a = 1'b1;
    push(32'hDEAD_BEEF);
    for (int i = 0; i < 200 && !(ifa.cs_n === 1'b0 && rise_cnt == 10); i++) tick();
    chk("abort_reached_edge10", 32'(rise_cnt), 32'd10);
    abort_pend = 1'b1;
    rst = 1'b1;
    tick();
    chk("abort_cs_n", 32'(ifa.cs_n), 32'd1);
    chk("abort_sclk", 32'(ifa.sclk), 32'd0);
    chk("abort_fc",   32'(fc_a),     32'd0);
    rst = 1'b0;
    tick(3);
    push(32'h1234_5678);
    wait_frames(16'd1);
    tick();
    en_a = 1'b0;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    // DATA_W=8, CLK_DIV=1 instance
    ifb.dac_fifo_out = 8'hC6;
    ifb.empty_dac = 1'b0;
    en_b = 1'b1;
    for (int i = 0; i < 20 && ifb.rd_dac !== 1'b1; i++) @(negedge clk);
    chk("b_rd", 32'(ifb.rd_dac), 32'd1);
    @(posedge clk); #2;
    ifb.empty_dac = 1'b1;
    en_b = 1'b0;
    for (int i = 0; i < 100 && fc_b != 16'd1; i++) tick();
    tick();
    chk("b_frame_cnt", 32'(fc_b),   32'd1);
    chk("b_cs_low",    32'(b_low),  32'd16);
    chk("b_bits",      32'(b_rise), 32'd8);
    chk("b_word",      32'(b_word), 32'hC6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
